dither_modulator: RTL
=====================

DITHER_MODULATOR -- requirements
Module: dither_modulator

Interface
REQ-001 Parameter counterMax, default 31, meaning the terminal value of the oscillator phase counter; the counter counts 0..counterMax.
REQ-002 Parameter rampStep, default 16, meaning the amplitude slew increment applied per carrier half-cycle.
REQ-003 master_clk  input  1  single clock (64 MHz); all logic on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = modulate toward amplitudeRegIn; 0 = ramp amplitude to zero.
REQ-006 amplitudeRegIn  input  13 (unsigned)  target carrier amplitude, 0..8191.
REQ-007 offsetRegIn  input  14 (signed)  DC/baseband offset added to the carrier.
REQ-008 tx_out  output  14 (signed)  modulated DAC word.
REQ-009 OscCounter  output  6  oscillator phase counter, shared with the downstream demodulator.
REQ-010 OscSign  output  1  carrier half-cycle sign, shared with the downstream demodulator.
REQ-011 cycle_strobe  output  1  one-cycle pulse at the start of each full carrier period.

Function
REQ-012 OscCounter SHALL increment by 1 every clock and wrap from counterMax to 0.
REQ-013 OscSign SHALL toggle on the same clock edge on which OscCounter wraps to 0; the carrier period is 2*(counterMax+1) clocks (64 clocks = 1 MHz at default settings).
REQ-014 cycle_strobe SHALL be 1 for exactly the single clock in which OscCounter=0 and OscSign=0 (after a wrap), and 0 otherwise.
REQ-015 The internal activeAmp register (13-bit unsigned) SHALL update only on the edge on which OscSign toggles, so that amplitude never changes mid half-cycle.
REQ-016 The ramp target SHALL be amplitudeRegIn when enable=1 and 0 when enable=0, sampled on the toggle edge.
REQ-017 If |target-activeAmp| <= rampStep, activeAmp SHALL be set to target; otherwise activeAmp SHALL move rampStep toward target (no overshoot, no wrap).
REQ-018 Changes to amplitudeRegIn or enable between toggle edges SHALL have no effect until the next toggle edge.
REQ-019 The carrier term SHALL be +activeAmp when OscSign=0 and -activeAmp when OscSign=1.
REQ-020 The sum offsetRegIn + carrier SHALL be computed at 15-bit signed width and saturated to [-8192, 8191].
REQ-021 tx_out SHALL be registered with a latency of 1 clock relative to the OscSign/activeAmp values it reflects.
REQ-022 When activeAmp=0, tx_out SHALL equal offsetRegIn, delayed by 1 clock.
REQ-023 OscCounter and OscSign SHALL free-run regardless of enable.

Reset
REQ-024 While reset=1, the following SHALL be held at 0 asynchronously: OscCounter, OscSign, activeAmp, tx_out and cycle_strobe.
REQ-025 On the first clock after reset deasserts, OscCounter SHALL become 1.
REQ-026 Assertion of reset mid-ramp or mid-period SHALL abort immediately; there SHALL be no residual amplitude after release.

Verification
REQ-027 Free-run: reset, then 128 clocks -> OscCounter wraps every 32 clocks; OscSign toggles at clocks 32, 64, 96, 128; cycle_strobe pulses at clocks 64 and 128 only.
REQ-028 Ramp up: enable=1, amplitudeRegIn=40, offset=0 -> activeAmp steps 16, 32, 40 on successive toggles; tx_out = +16/-32/+40 pattern per half-cycle, 1 clock after each toggle.
REQ-029 Ramp down: from activeAmp=40, enable=0 -> activeAmp = 24, 8, 0; thereafter tx_out = offsetRegIn.
REQ-030 Saturation: activeAmp=8191, offsetRegIn=100 -> tx_out=8191 during OscSign=0 and -8091 during OscSign=1; with offsetRegIn=-100 -> -8192 during OscSign=1.
REQ-031 Mid half-cycle change: amplitudeRegIn changes 40->1000 at OscCounter=10 -> activeAmp is unchanged until the next toggle, then becomes 56.
REQ-032 Reset mid-ramp: assert reset for 3 clocks with activeAmp=32 -> all outputs are 0 immediately; after release the ramp restarts from 0 (first step 16).

Source files
------------

// File: rtl/dither_modulator.sv
// dither_modulator
// Square-wave dither carrier generator. A free-running phase counter and
// half-cycle sign define the carrier; the carrier amplitude slews toward its
// target only on half-cycle boundaries, and the offset-plus-carrier sum is
// saturated to 14-bit signed and registered onto tx_out.
module dither_modulator #(
   parameter int counterMax = 31,
   parameter int rampStep   = 16
) (
   input  logic        master_clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [12:0] amplitudeRegIn,
   input  logic [13:0] offsetRegIn,
   output logic [13:0] tx_out,
   output logic [5:0]  OscCounter,
   output logic        OscSign,
   output logic        cycle_strobe
);

   localparam logic [5:0]  COUNTER_MAX = 6'(counterMax);
   localparam logic [13:0] RAMP_STEP   = 14'(rampStep);

   // Moves cur toward tgt by at most RAMP_STEP, landing exactly on tgt when close.
   function automatic logic [12:0] ramp_toward(input logic [12:0] cur,
                                               input logic [12:0] tgt);
      logic [13:0] diff;
      logic [12:0] res;
      if (tgt >= cur) begin
         diff = {1'b0, tgt} - {1'b0, cur};
         if (diff <= RAMP_STEP) begin
            res = tgt;
         end else begin
            res = cur + RAMP_STEP[12:0];
         end
      end else begin
         diff = {1'b0, cur} - {1'b0, tgt};
         if (diff <= RAMP_STEP) begin
            res = tgt;
         end else begin
            res = cur - RAMP_STEP[12:0];
         end
      end
      return res;
   endfunction

   // Clamps a 15-bit signed sum into the 14-bit signed DAC range.
   function automatic logic [13:0] sat14(input logic signed [14:0] sum);
      logic [13:0] res;
      if (sum > 15'sd8191) begin
         res = 14'h1FFF;
      end else if (sum < -15'sd8192) begin
         res = 14'h2000;
      end else begin
         res = sum[13:0];
      end
      return res;
   endfunction

   logic [5:0]         osc_counter_r;
   logic               osc_sign_r;
   logic               cycle_strobe_r;
   logic [12:0]        active_amp_r;
   logic [13:0]        tx_out_r;

   logic               wrap_s;
   logic [5:0]         counter_next_s;
   logic [12:0]        target_s;
   logic [12:0]        amp_next_s;
   logic signed [14:0] amp_ext_s;
   logic signed [14:0] offset_ext_s;
   logic signed [14:0] carrier_s;
   logic signed [14:0] sum_s;
   logic [13:0]        tx_next_s;

   // Phase counter wrap detection and next count.
   always_comb begin
      wrap_s         = 1'b0;
      counter_next_s = 6'd0;
      if (osc_counter_r == COUNTER_MAX) begin
         wrap_s         = 1'b1;
         counter_next_s = 6'd0;
      end else begin
         wrap_s         = 1'b0;
         counter_next_s = osc_counter_r + 6'd1;
      end
   end

   // Ramp target selection and the slewed amplitude for the next half-cycle.
   always_comb begin
      target_s = 13'd0;
      if (enable) begin
         target_s = amplitudeRegIn;
      end else begin
         target_s = 13'd0;
      end
      amp_next_s = ramp_toward(active_amp_r, target_s);
   end

   // Signed carrier (+amp on positive half, -amp on negative half) plus offset, saturated.
   always_comb begin
      amp_ext_s    = $signed({2'b00, active_amp_r});
      offset_ext_s = $signed({offsetRegIn[13], offsetRegIn});
      carrier_s    = 15'sd0;
      if (osc_sign_r) begin
         carrier_s = -amp_ext_s;
      end else begin
         carrier_s = amp_ext_s;
      end
      sum_s     = offset_ext_s + carrier_s;
      tx_next_s = sat14(sum_s);
   end

   // Free-running phase counter, half-cycle sign and full-period strobe.
   always_ff @(posedge master_clk or posedge reset) begin
      if (reset) begin
         osc_counter_r  <= 6'd0;
         osc_sign_r     <= 1'b0;
         cycle_strobe_r <= 1'b0;
      end else begin
         osc_counter_r  <= counter_next_s;
         // strobe marks the period start: a wrap that returns the sign to positive
         cycle_strobe_r <= wrap_s & osc_sign_r;
         if (wrap_s) begin
            osc_sign_r <= ~osc_sign_r;
         end else begin
            osc_sign_r <= osc_sign_r;
         end
      end
   end

   // Amplitude only changes on a sign toggle so each half-cycle is flat.
   always_ff @(posedge master_clk or posedge reset) begin
      if (reset) begin
         active_amp_r <= 13'd0;
      end else if (wrap_s) begin
         active_amp_r <= amp_next_s;
      end else begin
         active_amp_r <= active_amp_r;
      end
   end

   // Registered DAC word, one clock behind the sign/amplitude it reflects.
   always_ff @(posedge master_clk or posedge reset) begin
      if (reset) begin
         tx_out_r <= 14'd0;
      end else begin
         tx_out_r <= tx_next_s;
      end
   end

   assign tx_out       = tx_out_r;
   assign OscCounter   = osc_counter_r;
   assign OscSign      = osc_sign_r;
   assign cycle_strobe = cycle_strobe_r;

endmodule
